// File: rtl/uartrx.sv
// uartrx -- 8N1 UART receiver (1 start bit, 8 data bits LSB first, 1 stop bit, no parity).
//
// The serial pin goes through a 2-FF synchronizer. A five-state FSM then samples it:
// - the start bit is checked at its midpoint;
// - each data bit and the stop bit are sampled one full bit period later.
// A good stop bit delivers the byte with a one-cycle o_RX_DV strobe.
// A bad stop bit (sampled 0) gives a one-cycle o_RX_Frame_Err strobe instead, and start
// detection is disarmed until the line has been seen high again. This keeps a break
// condition (line held low) from producing a stream of bogus frames.
//
// Handshake: o_RX_DV is a valid-only strobe with no ready. The receiver cannot be stalled,
// so the consumer must capture o_RX_Byte in the cycle o_RX_DV is high. o_RX_Byte then
// holds its value until the next good frame.
//
// Optional feature (define UARTRX_MAJORITY_EN): every sample point takes the majority of
// the last three synchronized line values. This rejects single-cycle glitches. Without
// the macro, each sample is the single synchronized line value.
//
// Parameters:
//   CLKS_PER_BIT   clocks per bit = f(i_Clock)/baud, legal range 8..255
// Ports:
//   i_Clock        clock, rising edge
//   i_Reset        synchronous active-high reset
//   i_RX_Serial    asynchronous serial input, idle high
//   o_RX_DV        one-cycle strobe: o_RX_Byte holds a freshly received byte
//   o_RX_Byte      last good byte
//   o_RX_Active    high from start-bit detect until the FSM returns to IDLE
//   o_RX_Frame_Err one-cycle strobe: stop bit sampled 0
//   o_Debug_State  current FSM state encoding (debug observation only)
module uartrx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_RX_Frame_Err,
    output logic [2:0] o_Debug_State
);

    localparam logic [7:0] HALF_CNT = 8'((CLKS_PER_BIT - 1) / 2);
    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RX_START_BIT = 3'd1,
        RX_DATA_BITS = 3'd2,
        RX_STOP_BIT  = 3'd3,
        CLEANUP      = 3'd4
    } state_t;

    state_t     r_State, w_State_Next;
    logic       r_RX_s1, r_RX_s2;
    logic [7:0] r_Count, w_Count_Next;
    logic [2:0] r_Bit_Index, w_Bit_Index_Next;
    logic [7:0] r_RX_Shift, w_RX_Shift_Next;
    logic       r_Armed, w_Armed_Next;
    logic [7:0] w_RX_Byte_Next;
    logic       w_RX_DV_Next, w_Frame_Err_Next, w_RX_Active_Next;
    logic       w_Sample;

    // Both synchronizer stages reset to the idle (high) level, so reset never looks like a start bit.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_RX_s1 <= 1'b1;
            r_RX_s2 <= 1'b1;
        end else begin
            r_RX_s1 <= i_RX_Serial;
            r_RX_s2 <= r_RX_s1;
        end
    end

`ifdef UARTRX_MAJORITY_EN
    // Bit [0] holds the line one cycle ago; bit [1] holds it two cycles ago.
    logic [1:0] r_Line_Hist;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) r_Line_Hist <= 2'b11;
        else         r_Line_Hist <= {r_Line_Hist[0], r_RX_s2};
    end

    assign w_Sample = (r_RX_s2 & r_Line_Hist[0]) | (r_RX_s2 & r_Line_Hist[1]) |
                      (r_Line_Hist[0] & r_Line_Hist[1]);
`else
    assign w_Sample = r_RX_s2;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State        <= IDLE;
            r_Count        <= 8'd0;
            r_Bit_Index    <= 3'd0;
            r_RX_Shift     <= 8'd0;
            r_Armed        <= 1'b1;
            o_RX_Byte      <= 8'd0;
            o_RX_DV        <= 1'b0;
            o_RX_Frame_Err <= 1'b0;
            o_RX_Active    <= 1'b0;
        end else begin
            r_State        <= w_State_Next;
            r_Count        <= w_Count_Next;
            r_Bit_Index    <= w_Bit_Index_Next;
            r_RX_Shift     <= w_RX_Shift_Next;
            r_Armed        <= w_Armed_Next;
            o_RX_Byte      <= w_RX_Byte_Next;
            o_RX_DV        <= w_RX_DV_Next;
            o_RX_Frame_Err <= w_Frame_Err_Next;
            o_RX_Active    <= w_RX_Active_Next;
        end
    end

    always_comb begin
        w_State_Next     = r_State;
        w_Count_Next     = r_Count;
        w_Bit_Index_Next = r_Bit_Index;
        w_RX_Shift_Next  = r_RX_Shift;
        w_RX_Byte_Next   = o_RX_Byte;
        w_RX_Active_Next = o_RX_Active;
        // Strobes default low, so each one lasts exactly the cycle after its sample point.
        w_RX_DV_Next     = 1'b0;
        w_Frame_Err_Next = 1'b0;
        // Any cycle with the line high re-arms start detection; a framing error overrides it below.
        w_Armed_Next     = r_Armed | r_RX_s2;

        case (r_State)
            IDLE: begin
                w_Count_Next     = 8'd0;
                w_Bit_Index_Next = 3'd0;
                if (!r_RX_s2 && r_Armed) begin
                    w_State_Next     = RX_START_BIT;
                    w_RX_Active_Next = 1'b1;
                end
            end

            RX_START_BIT: begin
                if (r_Count == HALF_CNT) begin
                    if (!w_Sample) begin
                        w_Count_Next = 8'd0;
                        w_State_Next = RX_DATA_BITS;
                    end else begin
                        // The line went back high before mid-bit: treat it as noise.
                        w_State_Next     = IDLE;
                        w_RX_Active_Next = 1'b0;
                    end
                end else begin
                    w_Count_Next = r_Count + 8'd1;
                end
            end

            RX_DATA_BITS: begin
                if (r_Count == LAST_CNT) begin
                    w_Count_Next                 = 8'd0;
                    w_RX_Shift_Next[r_Bit_Index] = w_Sample;
                    if (r_Bit_Index == 3'd7) w_State_Next     = RX_STOP_BIT;
                    else                     w_Bit_Index_Next = r_Bit_Index + 3'd1;
                end else begin
                    w_Count_Next = r_Count + 8'd1;
                end
            end

            RX_STOP_BIT: begin
                if (r_Count == LAST_CNT) begin
                    if (w_Sample) begin
                        w_RX_Byte_Next = r_RX_Shift;
                        w_RX_DV_Next   = 1'b1;
                    end else begin
                        w_Frame_Err_Next = 1'b1;
                        w_Armed_Next     = 1'b0;
                    end
                    w_State_Next = CLEANUP;
                end else begin
                    w_Count_Next = r_Count + 8'd1;
                end
            end

            CLEANUP: begin
                w_RX_Active_Next = 1'b0;
                w_State_Next     = IDLE;
            end

            default: begin
                w_State_Next     = IDLE;
                w_RX_Active_Next = 1'b0;
            end
        endcase
    end

    assign o_Debug_State = r_State;

endmodule

// File: tb/tb_uartrx.sv
// Testbench for uartrx at CLKS_PER_BIT=16.
// Driver tasks emit 8N1 frames cycle by cycle. For each frame the reference model predicts:
// - the outcome (good byte or framing error);
// - the byte visible at the strobe;
// - the cycle of the strobe, from the frame start and the bit period.
// That prediction goes into exp_q. A negedge monitor pops and compares on every strobe.
module tb_uartrx;

    localparam int CPB = 16;
    localparam int H   = (CPB - 1) / 2;
    localparam int W   = 41;  // {is_err, byte[7:0], strobe_cycle[31:0]}

    logic       clk;
    logic       rst;
    logic       rx_serial;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       rx_active;
    logic       rx_frame_err;
    logic [2:0] dbg_state;

    logic [W-1:0] exp_q[$];
    logic [7:0]   last_good;
    int           cyc;
    int           act_total;
    int           n_checks;
    int           n_pass;

    uartrx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_RX_Serial    (rx_serial),
        .o_RX_DV        (rx_dv),
        .o_RX_Byte      (rx_byte),
        .o_RX_Active    (rx_active),
        .o_RX_Frame_Err (rx_frame_err),
        .o_Debug_State  (dbg_state)
    );

    // ---------------- clock / cycle counters ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc       = 0;
        act_total = 0;
        n_checks  = 0;
        n_pass    = 0;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rx_active) act_total <= act_total + 1;

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // ---------------- driver tasks (called #1 after a rising edge) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_serial = 1'b1;
        repeat (n) tick();
    endtask

    // Sends one frame. glitch_bit >= 0 forces a one-cycle high pulse onto that data bit.
    // The pulse is placed on the input two edges before the bit's sample point, because the
    // synchronizer delays the line by two cycles.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int glitch_bit);
        logic [9:0] bits;
        logic [7:0] exp_byte;
        logic       err;
        int         t0;
        bits     = {stop, data, 1'b0};
        err      = !stop;
        exp_byte = data;
`ifndef UARTRX_MAJORITY_EN
        if (glitch_bit >= 0) exp_byte[glitch_bit] = 1'b1;
`endif
        if (err) exp_byte  = last_good;
        else     last_good = exp_byte;
        t0 = cyc + 1;  // the next edge is the first one that samples the start bit
        // The stop bit is sampled at T0+3+H+9*CPB; the strobe is visible right after that edge.
        exp_q.push_back({err, exp_byte, 32'(t0 + 3 + H + 9 * CPB)});
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < CPB; k++) begin
                rx_serial = bits[b];
                if (glitch_bit >= 0 && b == glitch_bit + 1 && k == H + 1) rx_serial = 1'b1;
                tick();
            end
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rx_dv || rx_frame_err) begin
            check("strobe_exclusive", 32'(rx_dv & rx_frame_err), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, rx_dv, rx_frame_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("frame_err_kind", 32'(rx_frame_err), 32'(e[40]));
                check("rx_byte", 32'(rx_byte), 32'(e[39:32]));
                check("strobe_cycle", 32'(cyc), e[31:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int a0;
        int w;
        logic [9:0] bits;
        logic [7:0] d;
        logic       s;

        rst       = 1'b1;
        rx_serial = 1'b1;
        last_good = 8'h00;
        repeat (3) tick();
        check("reset_dv", 32'(rx_dv), 32'd0);
        check("reset_byte", 32'(rx_byte), 32'd0);
        check("reset_active", 32'(rx_active), 32'd0);
        check("reset_frame_err", 32'(rx_frame_err), 32'd0);
        check("reset_state_idle", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        idle(20);

        // Single clean byte.
        send_frame(8'hA5, 1'b1, -1);
        idle(20);

        // False start: 4 low cycles. Active spans edges T0+2 .. T0+3+H, i.e. H+1 sampled
        // cycles; the inclusive count of that span is H+2.
        a0 = act_total;
        rx_serial = 1'b0;
        repeat (4) tick();
        idle(30);
        check_range("false_start_active_cycles", act_total - a0, H + 1, H + 2);
        check("false_start_active_low", 32'(rx_active), 32'd0);
        send_frame(8'h3C, 1'b1, -1);
        idle(20);

        // Framing error followed by a 40-bit-time break.
        send_frame(8'h3C, 1'b0, -1);
        rx_serial = 1'b0;
        a0 = act_total;
        repeat (40 * CPB) tick();
        check("break_no_start", 32'(act_total - a0), 32'd0);
        check("break_state_idle", 32'(dbg_state), 32'd0);
        idle(10);
        send_frame(8'h81, 1'b1, -1);
        idle(20);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        idle(20);

        // Reset during data bit 4. Bits 4..7 and the stop bit of 0xF3 are high, so the
        // line stays idle after reset and the abandoned frame must not produce a strobe.
        bits = {1'b1, 8'hF3, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < CPB; k++) begin
                rx_serial = bits[b];
                if (b == 5 && k == 5) rst = 1'b1;
                tick();
                if (rst) begin
                    rst = 1'b0;
                    check("midreset_dv", 32'(rx_dv), 32'd0);
                    check("midreset_byte", 32'(rx_byte), 32'd0);
                    check("midreset_active", 32'(rx_active), 32'd0);
                    check("midreset_frame_err", 32'(rx_frame_err), 32'd0);
                end
            end
        end
        last_good = 8'h00;
        idle(20);
        send_frame(8'h5A, 1'b1, -1);
        idle(20);

        // Glitch at the bit-2 sample point.
        send_frame(8'hF0, 1'b1, 2);
        idle(20);

        // Randomized frames: mostly good, occasional framing errors, random gaps.
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 4) != 0);
            send_frame(d, s, -1);
            // After a framing error the line must be seen high before the next start.
            if (!s) idle($urandom_range(3, 20));
            else    idle($urandom_range(0, 20));
        end

        // Drain the scoreboard.
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            tick();
            w++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
